retire_map_unit: RTL and testbench

// Retire-side producer for the N-way physical-register freelist. Each cycle it takes up to N
// in-order ROB head entries and retires the longest eligible prefix. It commits their

---
 rtl/retire_map_unit_pkg.sv | 30 +++
 rtl/retire_map_unit_select.sv | 42 ++++
 rtl/retire_map_unit.sv | 162 ++++++++++++++++
 tb/tb_retire_map_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_map_unit_pkg.sv
// Shared widths, ROB head packet and retire FSM encoding for the retire/map-table slice.
package retire_map_unit_pkg;

    localparam int N_LANES    = 3;
    localparam int PR_COUNT   = 64;
    localparam int ARCH_COUNT = 32;
    localparam int TW         = $clog2(PR_COUNT);
    localparam int AW         = $clog2(ARCH_COUNT);

    typedef logic [TW-1:0] phys_tag_t;
    typedef logic [AW-1:0] arch_tag_t;

    typedef struct packed {
        logic      valid;
        logic      done;
        logic      dest_valid;
        arch_tag_t arch_dest;
        phys_tag_t new_tag;
        phys_tag_t old_tag;
        logic      mispred;
        logic      halt;
    } rob_retire_packet_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_HALTED  = 2'd2
    } retire_state_t;

endpackage

// File: rtl/retire_map_unit_select.sv
// Retire-prefix selection: lane i retires only if every older lane retired and none of
// them stopped retirement by being a mispredicted branch or a halt.
module retire_select #(
    parameter int N  = 3,
    parameter int CW = $clog2(N+1)
) (
    input  logic          i_enable,
    input  logic [N-1:0]  i_valid,
    input  logic [N-1:0]  i_done,
    input  logic [N-1:0]  i_mispred,
    input  logic [N-1:0]  i_halt,
    output logic [N-1:0]  o_mask,
    output logic [CW-1:0] o_count,
    output logic          o_stop_mispred,
    output logic          o_stop_halt
);

    logic w_open;

    always_comb begin
        o_mask  = '0;
        o_count = '0;
        w_open  = i_enable;
        for (int i = 0; i < N; i++) begin
            if (w_open && i_valid[i] && i_done[i]) begin
                o_mask[i] = 1'b1;
                o_count   = o_count + CW'(1);
                // The stopping lane itself retires; everything younger waits.
                if (i_mispred[i] || i_halt[i]) begin
                    w_open = 1'b0;
                end
            end else begin
                w_open = 1'b0;
            end
        end
    end

    // A halt on the same lane as a mispredict takes precedence.
    assign o_stop_halt    = |(o_mask & i_halt);
    assign o_stop_mispred = |(o_mask & i_mispred & ~i_halt);

endmodule

// File: rtl/retire_map_unit.sv
// Retire stage: commits ROB head mappings into the architectural map, returns old tags
// to the freelist, and raises the one-cycle recovery pulse on a retired mispredict.
module retire_map_unit
    import retire_map_unit_pkg::*;
#(
    parameter  int N  = N_LANES,
    localparam int CW = $clog2(N+1)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [N-1:0]                   rob_valid,
    input  logic [N-1:0]                   rob_done,
    input  logic [N-1:0]                   rob_dest_valid,
    input  logic [N-1:0][AW-1:0]           rob_arch_dest,
    input  logic [N-1:0][TW-1:0]           rob_new_tag,
    input  logic [N-1:0][TW-1:0]           rob_old_tag,
    input  logic [N-1:0]                   rob_mispred,
    input  logic [N-1:0]                   rob_halt,
    output logic [CW-1:0]                  retire_count,
    output logic [N-1:0]                   RetireEN,
    output logic [N-1:0][TW-1:0]           RetireReg,
    output logic                           BPRecoverEN,
    output logic [ARCH_COUNT-1:0][TW-1:0]  archi_maptable,
    output logic                           halted,
    output logic [63:0]                    retired_total,
    output retire_state_t                  dbg_state
);

    rob_retire_packet_t                w_pkt [N];
    logic [N-1:0]                      w_valid;
    logic [N-1:0]                      w_done;
    logic [N-1:0]                      w_mispred;
    logic [N-1:0]                      w_halt;
    logic [N-1:0]                      w_mask;
    logic [N-1:0]                      w_commit;
    logic [CW-1:0]                     w_count;
    logic                              w_stop_mispred;
    logic                              w_stop_halt;
    logic                              w_run;
    retire_state_t                     w_state_next;
    logic [ARCH_COUNT-1:0][TW-1:0]     w_map_next;

    retire_state_t                     r_state;
    logic [ARCH_COUNT-1:0][TW-1:0]     r_map;
    logic [N-1:0]                      r_retire_en;
    logic [N-1:0][TW-1:0]              r_retire_reg;
    logic                              r_bp_recover;
    logic                              r_halted;
    logic [63:0]                       r_total;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_pkt[i].valid      = rob_valid[i];
            w_pkt[i].done       = rob_done[i];
            w_pkt[i].dest_valid = rob_dest_valid[i];
            w_pkt[i].arch_dest  = rob_arch_dest[i];
            w_pkt[i].new_tag    = rob_new_tag[i];
            w_pkt[i].old_tag    = rob_old_tag[i];
            w_pkt[i].mispred    = rob_mispred[i];
            w_pkt[i].halt       = rob_halt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_valid[i]   = w_pkt[i].valid;
            w_done[i]    = w_pkt[i].done;
            w_mispred[i] = w_pkt[i].mispred;
            w_halt[i]    = w_pkt[i].halt;
        end
    end

    assign w_run = (r_state == ST_RUN);

    retire_select #(
        .N  (N),
        .CW (CW)
    ) u_select (
        .i_enable       (w_run),
        .i_valid        (w_valid),
        .i_done         (w_done),
        .i_mispred      (w_mispred),
        .i_halt         (w_halt),
        .o_mask         (w_mask),
        .o_count        (w_count),
        .o_stop_mispred (w_stop_mispred),
        .o_stop_halt    (w_stop_halt)
    );

    // Register x0 is hardwired: it never enters the map and never frees a tag.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_commit[i] = w_mask[i] && w_pkt[i].dest_valid && (w_pkt[i].arch_dest != '0);
        end
    end

    // Lanes are applied oldest first, so the youngest writer of an arch reg wins.
    always_comb begin
        w_map_next = r_map;
        for (int i = 0; i < N; i++) begin
            if (w_commit[i]) begin
                w_map_next[w_pkt[i].arch_dest] = w_pkt[i].new_tag;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_stop_halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_stop_mispred) begin
                    w_state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: w_state_next = ST_RUN;
            ST_HALTED:  w_state_next = ST_HALTED;
            default:    w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ARCH_COUNT; r++) begin
                r_map[r] <= TW'(r);
            end
            r_retire_en  <= '0;
            r_retire_reg <= '0;
            r_bp_recover <= 1'b0;
            r_halted     <= 1'b0;
            r_total      <= '0;
        end else begin
            r_map <= w_map_next;
            for (int i = 0; i < N; i++) begin
                r_retire_en[i]  <= w_commit[i];
                r_retire_reg[i] <= w_commit[i] ? w_pkt[i].old_tag : '0;
            end
            r_bp_recover <= w_stop_mispred;
            r_halted     <= r_halted | w_stop_halt;
            r_total      <= r_total + 64'(w_count);
        end
    end

    assign retire_count   = w_count;
    assign RetireEN       = r_retire_en;
    assign RetireReg      = r_retire_reg;
    assign BPRecoverEN    = r_bp_recover;
    assign archi_maptable = r_map;
    assign halted         = r_halted;
    assign retired_total  = r_total;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_retire_map_unit.sv
// Bench for retire_map_unit: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a behavioural retire model.
module tb_retire_map_unit;
  import retire_map_unit_pkg::*;

  localparam int N  = 3;
  localparam int CW = $clog2(N+1);
  localparam int M_RUN     = 0;
  localparam int M_RECOVER = 1;
  localparam int M_HALTED  = 2;

  logic                          clock;
  logic                          reset_n;
  logic [N-1:0]                  rob_valid;
  logic [N-1:0]                  rob_done;
  logic [N-1:0]                  rob_dest_valid;
  logic [N-1:0][AW-1:0]          rob_arch_dest;
  logic [N-1:0][TW-1:0]          rob_new_tag;
  logic [N-1:0][TW-1:0]          rob_old_tag;
  logic [N-1:0]                  rob_mispred;
  logic [N-1:0]                  rob_halt;
  logic [CW-1:0]                 retire_count;
  logic [N-1:0]                  RetireEN;
  logic [N-1:0][TW-1:0]          RetireReg;
  logic                          BPRecoverEN;
  logic [ARCH_COUNT-1:0][TW-1:0] archi_maptable;
  logic                          halted;
  logic [63:0]                   retired_total;
  retire_state_t                 dbg_state;

  retire_map_unit #(.N(N)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rob_valid      (rob_valid),
    .rob_done       (rob_done),
    .rob_dest_valid (rob_dest_valid),
    .rob_arch_dest  (rob_arch_dest),
    .rob_new_tag    (rob_new_tag),
    .rob_old_tag    (rob_old_tag),
    .rob_mispred    (rob_mispred),
    .rob_halt       (rob_halt),
    .retire_count   (retire_count),
    .RetireEN       (RetireEN),
    .RetireReg      (RetireReg),
    .BPRecoverEN    (BPRecoverEN),
    .archi_maptable (archi_maptable),
    .halted         (halted),
    .retired_total  (retired_total),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                            m_mode;
  logic [ARCH_COUNT-1:0][TW-1:0] m_map;
  logic [N-1:0]                  m_en;
  logic [N-1:0][TW-1:0]          m_reg;
  logic                          m_bp;
  logic                          m_halted;
  logic [63:0]                   m_total;

  int                            p_mode;
  logic [ARCH_COUNT-1:0][TW-1:0] p_map;
  logic [N-1:0]                  p_en;
  logic [N-1:0][TW-1:0]          p_reg;
  logic                          p_bp;
  logic                          p_halted;
  logic [63:0]                   p_total;

  task automatic model_reset();
    m_mode = M_RUN;
    for (int r = 0; r < ARCH_COUNT; r++) m_map[r] = TW'(r);
    m_en = '0;
    m_reg = '0;
    m_bp = 1'b0;
    m_halted = 1'b0;
    m_total = '0;
  endtask

  always @(negedge reset_n) model_reset();

  // Compare process: check outputs against the model, then compute the next model state.
  always @(negedge clock) begin
    int  cnt;
    bit  stop_h;
    bit  stop_m;
    cnt = 0;
    stop_h = 0;
    stop_m = 0;
    if (m_mode == M_RUN) begin
      for (int i = 0; i < N; i++) begin
        if (!(rob_valid[i] && rob_done[i])) break;
        cnt++;
        if (rob_halt[i]) begin stop_h = 1; break; end
        if (rob_mispred[i]) begin stop_m = 1; break; end
      end
    end
    check("retire_count", 64'(retire_count), 64'(cnt));
    check("RetireEN", 64'(RetireEN), 64'(m_en));
    check("RetireReg", 64'(RetireReg), 64'(m_reg));
    check("BPRecoverEN", 64'(BPRecoverEN), 64'(m_bp));
    check("halted", 64'(halted), 64'(m_halted));
    check("retired_total", retired_total, m_total);
    n_checks++;
    if (archi_maptable !== m_map) begin
      n_errors++;
      $display("FAIL archi_maptable: got %h expected %h at %0t", archi_maptable, m_map, $time);
    end

    p_map = m_map;
    p_en = '0;
    p_reg = '0;
    for (int i = 0; i < cnt; i++) begin
      if (rob_dest_valid[i] && rob_arch_dest[i] != 0) begin
        p_en[i] = 1'b1;
        p_reg[i] = rob_old_tag[i];
        p_map[rob_arch_dest[i]] = rob_new_tag[i];
      end
    end
    p_total = m_total + 64'(cnt);
    p_bp = stop_m;
    p_halted = m_halted | stop_h;
    if (stop_h) p_mode = M_HALTED;
    else if (stop_m) p_mode = M_RECOVER;
    else if (m_mode == M_RECOVER) p_mode = M_RUN;
    else p_mode = m_mode;
  end

  always @(posedge clock) begin
    if (reset_n) begin
      m_mode = p_mode;
      m_map = p_map;
      m_en = p_en;
      m_reg = p_reg;
      m_bp = p_bp;
      m_halted = p_halted;
      m_total = p_total;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_lanes();
    rob_valid = '0;
    rob_done = '0;
    rob_dest_valid = '0;
    rob_arch_dest = '0;
    rob_new_tag = '0;
    rob_old_tag = '0;
    rob_mispred = '0;
    rob_halt = '0;
  endtask

  task automatic set_lane(input int i, input bit v, input bit d, input bit dv, input int arch,
                          input int new_t, input int old_t, input bit mp, input bit h);
    rob_valid[i] = v;
    rob_done[i] = d;
    rob_dest_valid[i] = dv;
    rob_arch_dest[i] = AW'(arch);
    rob_new_tag[i] = TW'(new_t);
    rob_old_tag[i] = TW'(old_t);
    rob_mispred[i] = mp;
    rob_halt[i] = h;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      set_lane(i, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, ARCH_COUNT-1), $urandom_range(0, PR_COUNT-1),
               $urandom_range(0, PR_COUNT-1), $urandom_range(0, 9) == 0,
               $urandom_range(0, 59) == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_lanes();
    reset_n = 1'b1;
    model_reset();
    #2;
    apply_reset();

    // Reset state
    for (int r = 0; r < ARCH_COUNT; r++) check("reset_map", 64'(archi_maptable[r]), 64'(r));
    check("reset_retire_en", 64'(RetireEN), 64'd0);
    check("reset_bp", 64'(BPRecoverEN), 64'd0);
    check("reset_total", retired_total, 64'd0);
    check("reset_count", 64'(retire_count), 64'd0);

    // Three lanes retire; x0 is skipped by the map and freelist
    next_cycle();
    set_lane(0, 1, 1, 1, 5, 40, 5, 0, 0);
    set_lane(1, 1, 1, 1, 6, 41, 6, 0, 0);
    set_lane(2, 1, 1, 1, 0, 42, 0, 0, 0);
    @(negedge clock);
    check("t2_count", 64'(retire_count), 64'd3);
    next_cycle();
    check("t2_en", 64'(RetireEN), 64'b011);
    check("t2_reg0", 64'(RetireReg[0]), 64'd5);
    check("t2_reg1", 64'(RetireReg[1]), 64'd6);
    check("t2_map5", 64'(archi_maptable[5]), 64'd40);
    check("t2_map6", 64'(archi_maptable[6]), 64'd41);
    check("t2_model_map5", 64'(m_map[5]), 64'd40);
    check("t2_model_en", 64'(m_en), 64'b011);

    // Lane 1 not done blocks lane 2
    clear_lanes();
    set_lane(0, 1, 1, 1, 8, 42, 8, 0, 0);
    set_lane(1, 1, 0, 1, 12, 43, 12, 0, 0);
    set_lane(2, 1, 1, 1, 9, 44, 9, 0, 0);
    @(negedge clock);
    check("t3_count", 64'(retire_count), 64'd1);
    next_cycle();
    check("t3_en", 64'(RetireEN), 64'b001);
    check("t3_map8", 64'(archi_maptable[8]), 64'd42);
    check("t3_map9", 64'(archi_maptable[9]), 64'd9);

    // Mispredict on lane 1 stops at lane 1 and opens a one-cycle recovery window
    clear_lanes();
    set_lane(0, 1, 1, 1, 10, 43, 10, 0, 0);
    set_lane(1, 1, 1, 0, 0, 0, 0, 1, 0);
    set_lane(2, 1, 1, 1, 11, 44, 11, 0, 0);
    @(negedge clock);
    check("t4_count", 64'(retire_count), 64'd2);
    next_cycle();
    check("t4_bp", 64'(BPRecoverEN), 64'd1);
    check("t4_model_bp", 64'(m_bp), 64'd1);
    check("t4_map10", 64'(archi_maptable[10]), 64'd43);
    check("t4_map11", 64'(archi_maptable[11]), 64'd11);
    clear_lanes();
    for (int i = 0; i < N; i++) set_lane(i, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("t4_recover_count", 64'(retire_count), 64'd0);
    next_cycle();
    check("t4_bp_low", 64'(BPRecoverEN), 64'd0);
    @(negedge clock);
    check("t4_resume_count", 64'(retire_count), 64'd3);
    next_cycle();

    // Two lanes writing the same arch reg
    clear_lanes();
    set_lane(0, 1, 1, 1, 7, 50, 7, 0, 0);
    set_lane(1, 1, 1, 1, 7, 51, 50, 0, 0);
    next_cycle();
    check("t5_map7", 64'(archi_maptable[7]), 64'd51);
    check("t5_en", 64'(RetireEN), 64'b011);
    check("t5_reg0", 64'(RetireReg[0]), 64'd7);
    check("t5_reg1", 64'(RetireReg[1]), 64'd50);
    check("t5_total", retired_total, 64'd11);
    check("t5_model_total", m_total, 64'd11);

    // Halt on lane 0 is terminal
    clear_lanes();
    set_lane(0, 1, 1, 0, 0, 0, 0, 0, 1);
    set_lane(1, 1, 1, 1, 3, 60, 3, 0, 0);
    set_lane(2, 1, 1, 1, 4, 61, 4, 0, 0);
    @(negedge clock);
    check("t6_count", 64'(retire_count), 64'd1);
    next_cycle();
    check("t6_halted", 64'(halted), 64'd1);
    for (int i = 0; i < N; i++) set_lane(i, 1, 1, 1, 3, 62, 3, 0, 0);
    @(negedge clock);
    check("t6_halted_count", 64'(retire_count), 64'd0);
    next_cycle();
    check("t6_halted_sticky", 64'(halted), 64'd1);
    check("t6_total", retired_total, 64'd12);
    check("t6_map3", 64'(archi_maptable[3]), 64'd3);

    // Reset asserted while the recovery pulse is high
    clear_lanes();
    apply_reset();
    next_cycle();
    set_lane(0, 1, 1, 1, 10, 45, 10, 1, 0);
    next_cycle();
    check("t7_bp", 64'(BPRecoverEN), 64'd1);
    check("t7_map10", 64'(archi_maptable[10]), 64'd45);
    reset_n = 1'b0;
    clear_lanes();
    #1;
    check("t7_bp_abort", 64'(BPRecoverEN), 64'd0);
    check("t7_map10_reset", 64'(archi_maptable[10]), 64'd10);
    check("t7_halted_reset", 64'(halted), 64'd0);
    check("t7_total_reset", retired_total, 64'd0);
    @(posedge clock);
    #3;
    reset_n = 1'b1;

    // Randomized phase, with occasional asynchronous resets
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      drive_random();
      if ((halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0) begin
        #2;
        reset_n = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b1;
      end
    end

    next_cycle();
    clear_lanes();
    next_cycle();
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
